mem_bank_rw: RTL and testbench
==============================

MEM_BANK_RW -- requirements
Module: mem_bank_rw

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: request address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width in bits; multiple of 8.
REQ-003 SHALL have parameter MEM_DEPTH, default 64: number of words; at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 2: accept-to-response latency in cycles; legal range 1..4.
REQ-005 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: block can accept a request.
REQ-009 SHALL have port req_wr, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: word address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH: write data.
REQ-012 SHALL have port req_be, input, DATA_WIDTH/8: byte enables; bit i covers bits [8i+7:8i].
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-015 SHALL have port rsp_rdata, output, DATA_WIDTH: read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_wr, output, 1: echo of req_wr for the responded request.
REQ-017 SHALL have port rsp_err, output, 1: address out of range.
REQ-018 SHALL have port init_done, output, 1: high once the power-up clear sweep has finished.

Function
REQ-019 SHALL implement the states INIT, IDLE, WAIT and RESP.
REQ-020 SHALL, in INIT, write zero to address 0..MEM_DEPTH-1, one word per cycle, hold req_ready=0, and go to IDLE after exactly MEM_DEPTH cycles, setting init_done=1 from then on.
REQ-021 SHALL drive req_ready=1 only in IDLE, giving exactly one outstanding request.
REQ-022 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1.
REQ-023 SHALL update a write on the accept edge, changing only the byte lanes whose req_be bit is 1; req_be=0 leaves the word unchanged and returns a normal response.
REQ-024 SHALL sample read data from the array on the accept edge.
REQ-025 SHALL flag rsp_err=1 for req_addr >= MEM_DEPTH, perform no array access, return rsp_rdata=0, and not wrap the address modulo MEM_DEPTH.
REQ-026 SHALL assert rsp_valid after the edge that is RD_LATENCY edges after acceptance: RD_LATENCY=1 goes IDLE->RESP; otherwise IDLE->WAIT->RESP, with the latency counter counting RD_LATENCY-1 cycles in WAIT.
REQ-027 SHALL apply the same latency to reads, writes and errors.
REQ-028 SHALL hold rsp_valid, rsp_rdata, rsp_wr and rsp_err stable in RESP until rsp_ready=1.
REQ-029 SHALL go RESP->IDLE on the response handshake edge; the next acceptance is possible no earlier than the following edge.
REQ-030 SHALL ignore req_* inputs whenever req_ready=0.

Reset
REQ-031 SHALL, while reset=1, asynchronously force state=INIT, sweep address=0, latency counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_wr=0, rsp_err=0 and init_done=0.
REQ-032 SHALL, when reset is asserted mid-transaction in WAIT or RESP, discard the pending response without a handshake and rerun the full INIT sweep.
REQ-033 SHALL NOT clear the array itself by asynchronous reset; clearing happens only through the INIT sweep.

Structure
REQ-034 SHALL place the state enum (INIT, IDLE, WAIT, RESP) and the constants RD_LATENCY_MIN=1 and RD_LATENCY_MAX=4 in shared package mem_pkg.
REQ-035 SHALL implement the byte-enable storage array as sub-module mem_be_array (write port and registered read port); the FSM, latency counter and response register stay in mem_bank_rw.
REQ-036 SHALL check DATA_WIDTH%8==0, MEM_DEPTH<=2**ADDR_WIDTH and RD_LATENCY in 1..4 by elaboration-time assertion.

Verification (DATA_WIDTH=32, MEM_DEPTH=64, RD_LATENCY=2)
REQ-037 SHALL cover init: release reset -> req_ready=0 for 64 cycles, init_done=1 from cycle 64; read addr 5 -> rsp_rdata=0x00000000, rsp_err=0.
REQ-038 SHALL cover byte enables: write addr 3 0xDEADBEEF be=4'b1111, then write addr 3 0x11223344 be=4'b0101 -> read addr 3 returns 0xDE22BE44.
REQ-039 SHALL cover out of range: read addr 64 -> rsp_err=1, rsp_rdata=0; write addr 70 0xFFFFFFFF -> rsp_err=1, and addr 6 still reads 0x00000000.
REQ-040 SHALL cover latency: accept at edge N -> rsp_valid=1 after edge N+2; with rsp_ready=1 -> rsp_valid=0 after edge N+3 and req_ready=1.
REQ-041 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and payload held stable, req_ready=0, and a new req_valid is not accepted until the handshake.
REQ-042 SHALL cover reset in RESP: assert reset while rsp_valid=1 -> rsp_valid=0 immediately, INIT reruns for 64 cycles, and addr 3 then reads 0x00000000.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state type and latency limits for the memory bank
//
// Purpose: single place for the bank controller state encoding and the legal
// read-latency window, so the top and any future users agree on both.
// Ports: none (package).

package mem_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Wide enough to hold RD_LATENCY_MAX-1.
    localparam int LAT_CNT_W = 3;

endpackage : mem_pkg

// File: rtl/mem_be_array.sv
// rtl/mem_be_array.sv - byte-enable word array with one write port and a registered read port
//
// Purpose: storage for mem_bank_rw. Writes update only enabled byte lanes;
// reads capture the addressed word into a register on the same edge.
// The array has no reset: contents are only cleared by explicit writes.
// Ports:
//   clk_i     - clock, rising edge
//   we_i      - write enable
//   waddr_i   - write word index
//   wdata_i   - write data
//   wbe_i     - byte enables, bit i covers wdata_i[8i+7:8i]
//   re_i      - read enable, captures mem[raddr_i] into rdata_o
//   raddr_i   - read word index
//   rdata_o   - registered read data, held until the next read

module mem_be_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int IDX_W      = 6
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wbe_i,
    input  logic                    re_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_be_array

// File: rtl/mem_bank_rw.sv
// rtl/mem_bank_rw.sv - single-outstanding read/write memory bank with fixed response latency
//
// Purpose: after reset, sweeps the array to zero (INIT), then accepts one
// request at a time, performs the access on the accept edge and returns a
// response RD_LATENCY edges later, held until the consumer takes it.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-high reset
//   req_valid  - request present
//   req_ready  - bank can accept a request (IDLE only)
//   req_wr     - 1 = write, 0 = read
//   req_addr   - word address; >= MEM_DEPTH is an error, never wrapped
//   req_wdata  - write data
//   req_be     - byte enables
//   rsp_valid  - response present
//   rsp_ready  - consumer accepts the response
//   rsp_rdata  - read data, 0 for writes and errors
//   rsp_wr     - echo of req_wr
//   rsp_err    - address out of range
//   init_done  - power-up clear sweep finished

module mem_bank_rw
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_wr,
    output logic                    rsp_err,
    output logic                    init_done
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
        $error("mem_bank_rw: DATA_WIDTH must be a multiple of 8");
    end
    if (MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_chk_depth
        $error("mem_bank_rw: MEM_DEPTH exceeds the address space");
    end
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_chk_lat
        $error("mem_bank_rw: RD_LATENCY out of range");
    end

    state_t                 state_q;
    logic [IDX_W-1:0]       sweep_q;
    logic [LAT_CNT_W-1:0]   lat_q;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic                   rsp_wr_q;
    logic                   rsp_err_q;
    logic                   init_done_q;
    logic                   pend_wr_q;
    logic                   pend_err_q;

    logic                   accept_d;
    logic                   addr_oob_d;
    logic                   init_we_d;
    logic                   arr_we_d;
    logic                   arr_re_d;
    logic [IDX_W-1:0]       arr_addr_d;
    logic [DATA_WIDTH-1:0]  arr_wdata_d;
    logic [BE_W-1:0]        arr_be_d;
    logic [DATA_WIDTH-1:0]  arr_rdata;

    // req_ready_q is only ever high in IDLE, so this alone qualifies acceptance.
    assign accept_d   = req_valid && req_ready_q;
    // Compare at full address width so out-of-range addresses are never aliased.
    assign addr_oob_d = {1'b0, req_addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH);

    // Gate the sweep with reset so clock edges during reset do not touch the array.
    assign init_we_d   = (state_q == INIT) && !reset;
    assign arr_we_d    = init_we_d || (accept_d && req_wr && !addr_oob_d);
    assign arr_re_d    = accept_d && !req_wr && !addr_oob_d;
    assign arr_addr_d  = (state_q == INIT) ? sweep_q : req_addr[IDX_W-1:0];
    assign arr_wdata_d = (state_q == INIT) ? '0 : req_wdata;
    assign arr_be_d    = (state_q == INIT) ? '1 : req_be;

    mem_be_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we_d),
        .waddr_i (arr_addr_d),
        .wdata_i (arr_wdata_d),
        .wbe_i   (arr_be_d),
        .re_i    (arr_re_d),
        .raddr_i (arr_addr_d),
        .rdata_o (arr_rdata)
    );

    // WAIT lasts RD_LATENCY-1 cycles and the first RESP cycle arms the
    // response registers, so rsp_valid rises RD_LATENCY edges after accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            lat_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_err_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (sweep_q == IDX_W'(MEM_DEPTH - 1)) begin
                        state_q     <= IDLE;
                        sweep_q     <= '0;
                        init_done_q <= 1'b1;
                        req_ready_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept_d) begin
                        req_ready_q <= 1'b0;
                        pend_wr_q   <= req_wr;
                        pend_err_q  <= addr_oob_d;
                        if (RD_LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            lat_q   <= LAT_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_q == LAT_CNT_W'(RD_LATENCY - 1)) begin
                        state_q <= RESP;
                        lat_q   <= '0;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= pend_wr_q;
                        rsp_err_q   <= pend_err_q;
                        rsp_rdata_q <= (pend_wr_q || pend_err_q) ? '0 : arr_rdata;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_wr_q    <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

endmodule : mem_bank_rw

// File: tb/tb_mem_bank_rw.sv
// tb/tb_mem_bank_rw.sv - directed table-driven bench for mem_bank_rw

module tb_mem_bank_rw;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_wr;
    logic        rsp_err;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    mem_bank_rw #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (64),
        .RD_LATENCY (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_wr    (rsp_wr),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after reset is released at a negedge.
    task automatic check_init_sweep(input string tag);
        int bad;
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (k < 64) begin
                if (req_ready !== 1'b0 || init_done !== 1'b0) bad++;
            end else begin
                chk({tag, "_init_done_at_64"}, {31'd0, init_done}, 32'd1);
                chk({tag, "_ready_at_64"}, {31'd0, req_ready}, 32'd1);
            end
        end
        chk({tag, "_ready_low_during_init"}, bad, 0);
    endtask

    task automatic do_req(input string name, input vec_t v);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready_seen"}, {31'd0, req_ready === 1'b1}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rsp_seen"}, {31'd0, rsp_valid === 1'b1}, 32'd1);
        chk({name, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk({name, "_wr"}, {31'd0, rsp_wr}, {31'd0, v.wr});
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        vec_t v;

        //          wr    addr   wdata          be       exp_rdata      err
        vecs[0]  = '{1'b0, 8'd5,   32'h0,        4'b0000, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 8'd3,   32'hDEADBEEF, 4'b1111, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 8'd3,   32'h11223344, 4'b0101, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 8'd3,   32'h0,        4'b0000, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b0, 8'd64,  32'h0,        4'b0000, 32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 8'd70,  32'hFFFFFFFF, 4'b1111, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 8'd6,   32'h0,        4'b0000, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b1, 8'd6,   32'hAABBCCDD, 4'b0000, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 8'd6,   32'h0,        4'b0000, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 8'd63,  32'h12345678, 4'b1000, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 8'd63,  32'h0,        4'b0000, 32'h12000000, 1'b0};
        vecs[11] = '{1'b0, 8'd255, 32'h0,        4'b0000, 32'h00000000, 1'b1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_init_done", {31'd0, init_done}, 32'd0);
        chk("reset_rsp_payload", {rsp_rdata[29:0], rsp_wr, rsp_err}, 32'd0);
        reset = 1'b0;
        check_init_sweep("por");

        for (int i = 0; i < NVEC; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Latency: accept edge N, valid after N+2, cleared after N+3.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'd3; req_be = 4'b0000;
        chk("lat_ready_before", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("lat_n0_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_n0_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("lat_n1_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lat_n2_rdata", rsp_rdata, 32'hDE22BE44);
        @(posedge clk); #1;
        chk("lat_n3_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_n3_ready", {31'd0, req_ready}, 32'd1);

        // Backpressure: response held, competing write to 63 must not land.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'd63; req_be = 4'b0000;
        @(posedge clk); #1;
        req_wr = 1'b1; req_wdata = 32'h0; req_be = 4'b1111;
        repeat (2) @(posedge clk);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12000000 || rsp_err !== 1'b0 ||
                rsp_wr !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        chk("bp_held_stable", bad, 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        v = '{1'b0, 8'd63, 32'h0, 4'b0000, 32'h12000000, 1'b0};
        do_req("bp_readback", v);

        // Reset while a response is pending.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'd3; req_be = 4'b0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_resp_valid_before", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_resp_valid_now", {31'd0, rsp_valid}, 32'd0);
        chk("rst_resp_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_resp_ready", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_init_sweep("rerun");
        v = '{1'b0, 8'd3, 32'h0, 4'b0000, 32'h00000000, 1'b0};
        do_req("rst_readback3", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_bank_rw
